// File: rtl/cache_pkg.sv
// cache_pkg: shared encodings for the cache-side sram-like arbiter
package cache_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
endpackage

// File: rtl/arb2_rr.sv
// arb2_rr: two-way combinational arbiter; port 1 wins ties unless round-robin points at port 0
module arb2_rr #(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb grant = &req ? ((RR_EN && last_grant) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/cache_sram_arbiter.sv
// cache_sram_arbiter: shares one sram-like port between i-cache and d-cache,
// one transaction in flight, handshakes routed only to the owner.
module cache_sram_arbiter import cache_pkg::*; #(
    parameter bit          RR_EN      = 1'b0,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok
);
    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic       last_q, last_d;
    logic [1:0] grant;
    logic       is_inst, is_data, aok, dok;

    arb2_rr #(.RR_EN(RR_EN)) u_arb (
        .req       ({data_req, inst_req}),
        .last_grant(last_q),
        .grant     (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // rst gates the response path so a completion racing a reset never reaches a cache
    always_comb begin
        is_inst = owner_q == OWN_INST;
        is_data = owner_q == OWN_DATA;
        aok     = !rst && state_q == ADDR && m_addr_ok;
        dok     = !rst && m_data_ok && (state_q == DATA || aok);
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (state_q == IDLE && |grant) begin
            state_d = ADDR;
            owner_d = grant[1] ? OWN_DATA : OWN_INST;
        end else if (aok && !dok) begin
            state_d = DATA;
        end
        if (dok) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            last_d  = is_data;
        end
        m_req        = !rst && state_q == ADDR;
        m_wr         = is_inst ? inst_wr    : is_data ? data_wr    : 1'b0;
        m_size       = is_inst ? inst_size  : is_data ? data_size  : 2'b00;
        m_addr       = is_inst ? inst_addr  : is_data ? data_addr  : '0;
        m_wdata      = is_inst ? inst_wdata : is_data ? data_wdata : '0;
        inst_addr_ok = aok && is_inst;
        data_addr_ok = aok && is_data;
        inst_data_ok = dok && is_inst;
        data_data_ok = dok && is_data;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
    end
endmodule

// File: tb/tb_cache_sram_arbiter.sv
// tb_cache_sram_arbiter: random cache/memory traffic against a transaction-level model,
// with instance 0 in fixed priority and instance 1 in round-robin.
module tb_cache_sram_arbiter;
    import cache_pkg::SIZE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ireq[2], iwr[2], dreq[2], dwr[2];
    logic        iaok[2], idok[2], daok[2], ddok[2];
    logic        mreq[2], mwr[2], maok[2], mdok[2];
    logic [1:0]  isz[2], dsz[2], msz[2];
    logic [31:0] iaddr[2], iwd[2], daddr[2], dwd[2];
    logic [31:0] ird[2], drd[2], maddr[2], mwd[2], mrd[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_sram_arbiter #(.RR_EN(g == 1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
            .clk(clk), .rst(rst),
            .inst_req(ireq[g]), .inst_wr(iwr[g]), .inst_size(isz[g]), .inst_addr(iaddr[g]),
            .inst_wdata(iwd[g]), .inst_rdata(ird[g]), .inst_addr_ok(iaok[g]), .inst_data_ok(idok[g]),
            .data_req(dreq[g]), .data_wr(dwr[g]), .data_size(dsz[g]), .data_addr(daddr[g]),
            .data_wdata(dwd[g]), .data_rdata(drd[g]), .data_addr_ok(daok[g]), .data_data_ok(ddok[g]),
            .m_req(mreq[g]), .m_wr(mwr[g]), .m_size(msz[g]), .m_addr(maddr[g]), .m_wdata(mwd[g]),
            .m_rdata(mrd[g]), .m_addr_ok(maok[g]), .m_data_ok(mdok[g])
        );
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // port index 0 = i-cache, 1 = d-cache
    bit          busy, acc, own, last;
    bit          pend[2], outst[2];
    bit          f_wr[2];
    logic [1:0]  f_sz[2];
    logic [31:0] f_addr[2], f_wd[2];
    int          p_req, p_aok, p_dok, p_same;
    bit          grants[$];

    function automatic bit rnd(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    task automatic reset_model();
        busy = 0; acc = 0; own = 0; last = 0;
        pend = '{0, 0};
        outst = '{0, 0};
        grants.delete();
    endtask

    task automatic issue(input int c, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        pend[c] = 1; outst[c] = 1;
        f_wr[c] = wr; f_sz[c] = SIZE_W; f_addr[c] = addr; f_wd[c] = wd;
    endtask

    task automatic step(input int k, input bit do_rst);
        bit aok, dok, both, exp_req, ok_a, ok_d;
        logic [31:0] rd;
        @(negedge clk);
        aok = 0; dok = 0;
        if (busy && !acc) begin
            aok = rnd(p_aok);
            dok = aok && rnd(p_same);
        end else if (busy) begin
            dok = rnd(p_dok);
        end
        if (do_rst) dok = 1;
        rd = $urandom;
        for (int c = 0; c < 2; c++)
            if (!outst[c] && rnd(p_req)) begin
                issue(c, 1'($urandom), $urandom, $urandom);
                f_sz[c] = 2'($urandom_range(2, 0));
            end
        rst = do_rst;
        maok[k] = aok; mdok[k] = dok; mrd[k] = rd;
        ireq[k] = pend[0]; iwr[k] = f_wr[0]; isz[k] = f_sz[0]; iaddr[k] = f_addr[0]; iwd[k] = f_wd[0];
        dreq[k] = pend[1]; dwr[k] = f_wr[1]; dsz[k] = f_sz[1]; daddr[k] = f_addr[1]; dwd[k] = f_wd[1];
        #1;
        exp_req = !do_rst && busy && !acc;
        ok_a = exp_req && aok;
        ok_d = !do_rst && busy && dok && (acc || aok);
        check("m_req", mreq[k], exp_req);
        if (exp_req) begin
            check("m_addr", maddr[k], f_addr[own]);
            check("m_wr", mwr[k], f_wr[own]);
            check("m_size", msz[k], f_sz[own]);
            check("m_wdata", mwd[k], f_wd[own]);
        end
        check("inst_addr_ok", iaok[k], ok_a && !own);
        check("data_addr_ok", daok[k], ok_a && own);
        check("inst_data_ok", idok[k], ok_d && !own);
        check("data_data_ok", ddok[k], ok_d && own);
        if (ok_d) check("rdata", own ? drd[k] : ird[k], rd);
        if (do_rst) begin
            if (busy && acc) outst[own] = 0;
            busy = 0; acc = 0; last = 0;
        end else if (busy) begin
            if (aok && !acc) begin
                acc = 1;
                pend[own] = 0;
            end
            if (dok && acc) begin
                busy = 0;
                last = own;
                outst[own] = 0;
            end
        end else if (pend[0] || pend[1]) begin
            both = pend[0] && pend[1];
            own = both ? (k == 1 ? !last : 1'b1) : pend[1];
            busy = 1; acc = 0;
            grants.push_back(own);
        end
    endtask

    task automatic start(input int k);
        reset_model();
        step(k, 1);
        step(k, 1);
    endtask

    task automatic run(input int k, input int n);
        repeat (n) step(k, 0);
    endtask

    task automatic knobs(input int rq, input int a, input int d, input int s);
        p_req = rq; p_aok = a; p_dok = d; p_same = s;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            ireq[c] = 0; iwr[c] = 0; isz[c] = 0; iaddr[c] = 0; iwd[c] = 0;
            dreq[c] = 0; dwr[c] = 0; dsz[c] = 0; daddr[c] = 0; dwd[c] = 0;
            maok[c] = 0; mdok[c] = 0; mrd[c] = 0;
        end
        knobs(0, 100, 100, 0);
        start(0);
        issue(0, 0, 32'h1FC0_0000, 32'h0);
        run(0, 6);
        check("single_grant", grants[0], 0);

        start(0);
        issue(0, 0, 32'h1FC0_0040, 32'h0);
        issue(1, 1, 32'h8000_0010, 32'h1234_5678);
        run(0, 10);
        check("fixed_first", grants[0], 1);
        check("fixed_second", grants[1], 0);
        grants.delete();
        issue(0, 0, 32'h1FC0_0080, 32'h0);
        issue(1, 1, 32'h8000_0010, 32'h1234_5678);
        run(0, 10);
        check("fixed_again", grants[0], 1);

        knobs(100, 100, 100, 0);
        start(1);
        run(1, 12);
        check("rr_0", grants[0], 1);
        check("rr_1", grants[1], 0);
        check("rr_2", grants[2], 1);

        knobs(60, 100, 100, 100);
        start(0);
        run(0, 20);
        start(1);
        run(1, 20);

        knobs(0, 100, 100, 0);
        start(0);
        issue(1, 1, 32'h0000_0100, 32'hCAFE_F00D);
        run(0, 5);
        issue(1, 0, 32'h0040_0100, 32'h0);
        run(0, 5);
        check("wb_refill_count", grants.size(), 2);

        knobs(0, 100, 0, 0);
        start(1);
        issue(0, 0, 32'h1FC0_0100, 32'h0);
        issue(1, 0, 32'h8000_0200, 32'h0);
        run(1, 3);
        step(1, 1);
        knobs(0, 100, 100, 0);
        run(1, 8);
        check("rst_regrant_count", grants.size(), 2);
        check("rst_regrant_owner", grants[1], 0);

        for (int k = 0; k < 2; k++) begin
            start(k);
            for (int n = 0; n < 400; n++) begin
                if (n % 50 == 0) knobs($urandom_range(80, 20), $urandom_range(90, 30), $urandom_range(90, 30), $urandom_range(60, 0));
                step(k, $urandom_range(99, 0) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_sram_arbiter.md
Name: cache_sram_arbiter

Overview:
Shares one downstream sram-like memory port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between the instruction cache and the data cache, which both issue sram-like transactions on a miss or dirty write-back. The block sits between {i_cache, d_cache} and the AXI bridge. It arbitrates, locks the winner for the whole transaction (one outstanding transaction total), and returns handshakes only to the owner.

Parameters:
RR_EN, 0, 0 = fixed priority (data wins every tie); 1 = round-robin between inst and data.
ADDR_WIDTH, 32, address width of all ports.
DATA_WIDTH, 32, wdata/rdata width.

Ports:
clk  in  1  clock
rst  in  1  reset
inst_req  in  1  i-cache request; held high with stable fields until inst_addr_ok
inst_wr  in  1  i-cache write flag (normally 0)
inst_size  in  2  i-cache access size
inst_addr  in  ADDR_WIDTH  i-cache address
inst_wdata  in  DATA_WIDTH  i-cache write data
inst_rdata  out  DATA_WIDTH  read data to i-cache
inst_addr_ok  out  1  address accepted, i-cache
inst_data_ok  out  1  transaction done, i-cache
data_req, data_wr, data_size, data_addr, data_wdata  in  same as inst_*  d-cache request fields
data_rdata, data_addr_ok, data_data_ok  out  same as inst_*  d-cache responses
m_req  out  1  downstream request
m_wr  out  1  downstream write flag
m_size  out  2  downstream size
m_addr  out  ADDR_WIDTH  downstream address
m_wdata  out  DATA_WIDTH  downstream write data
m_rdata  in  DATA_WIDTH  downstream read data
m_addr_ok  in  1  downstream address accepted
m_data_ok  in  1  downstream transaction done

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, owner=none, last_grant=INST (so data wins the first tie in RR mode). m_req, all *_addr_ok and *_data_ok are 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - m_req=0.
  - If inst_req|data_req: pick the winner and register owner, then go to ADDR. Grant latency is 1 cycle; m_req rises the cycle after the requester's req.
  - Winner selection, RR_EN=0: data if data_req, else inst.
  - Winner selection, RR_EN=1 with both requesting: the port not equal to last_grant wins. A single requester always wins.
- ADDR:
  - m_req=1. m_wr/m_size/m_addr/m_wdata are muxed from owner's inputs.
  - owner_addr_ok = m_addr_ok.
  - On m_addr_ok: go to DATA, unless m_data_ok is also high in the same cycle. In that case raise owner_data_ok and return to IDLE.
- DATA:
  - m_req=0.
  - On m_data_ok: owner_data_ok=1 for exactly that cycle, last_grant<=owner, go to IDLE.
- Non-owner ports: addr_ok=0 and data_ok=0 at all times, even if their req is high. Their req stays pending and is granted after the current transaction returns to IDLE.
- inst_rdata and data_rdata are both driven from m_rdata (broadcast). The value is only valid with that port's data_ok.
- Back-to-back: when a transaction completes, the next grant is evaluated in the IDLE cycle that follows. Minimum 3 cycles per transaction when addr_ok and data_ok are each single-cycle.
- In IDLE and DATA, m_* fields are driven from the owner mux (or 0 when owner=none). Downstream must ignore them when m_req=0.
- A requester dropping req while in ADDR is a protocol violation and is not guarded. The owner lock holds.
- Reset mid-transaction: the FSM returns to IDLE immediately and no data_ok is emitted. The downstream bridge is reset by the same rst.
- addr_ok/data_ok outputs are combinational from m_addr_ok/m_data_ok gated by state and owner. There is no added latency on the response path.

Decomposition:
- Shared package (cache_pkg): state encodings IDLE/ADDR/DATA, owner encodings OWN_NONE/OWN_INST/OWN_DATA, and sram-like size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
- One natural sub-module: arb2_rr. It takes 2 requests, last_grant and RR_EN, and outputs a one-hot grant. It is purely combinational, reusable, and unit-tested separately.

Test Plan:
1. Single inst read: inst_req=1, addr=0x1FC0_0000. Next cycle m_req=1 with m_addr=0x1FC0_0000. m_addr_ok in cycle 2, m_data_ok in cycle 4 with rdata=0xDEAD_BEEF → inst_addr_ok pulses in cycle 2, inst_data_ok pulses in cycle 4 with inst_rdata=0xDEAD_BEEF, data_* stay 0.
2. Simultaneous requests, RR_EN=0: inst_req and data_req (write to 0x8000_0010, wdata=0x1234_5678) both in the same cycle → data served first (m_wr=1, m_wdata=0x1234_5678), inst served next. Repeat the collision → data first again.
3. Simultaneous requests, RR_EN=1, three back-to-back collisions → grant order data, inst, data. Non-owner addr_ok/data_ok stay 0 throughout.
4. Same-cycle addr_ok and data_ok in ADDR → owner gets addr_ok and data_ok in the same cycle, FSM is in IDLE the next cycle.
5. Dirty write-back then refill: d-cache write to 0x0000_0100, then read of 0x0040_0100 held pending → two sequential downstream transactions, no overlap, m_req low between them.
6. rst asserted while in DATA → the next cycle state=IDLE, m_req=0, no data_ok pulse. A pending req is re-granted after rst deasserts.
